// File: rtl/fft_pkg.sv
// Shared types and frame geometry for the FFT input stage.
// The input chain is FFT_SEG_COUNT segments of FFT_SEG_DEPTH registers.
package fft_pkg;

    localparam int FFT_SEG_DEPTH = 8;
    localparam int FFT_SEG_COUNT = 8;
    localparam int FFT_N_POINTS  = FFT_SEG_COUNT * FFT_SEG_DEPTH;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        FULL = 2'd2
    } load_state_e;

endpackage

// File: rtl/fft_input_load_ctrl_if.sv
// Stream, chain-drive and frame-handshake bundle of the FFT input load controller.
// The flush signal exists only when FFT_INPUT_FLUSH_EN is defined.
interface fft_input_load_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_POINTS   = 64
);

    logic                          in_valid;
    logic [DATA_WIDTH-1:0]         in_data;
    logic                          in_ready;
    logic                          seg_hold;
    logic [DATA_WIDTH-1:0]         seg_D;
    logic                          frame_valid;
    logic                          frame_ack;
    logic [$clog2(N_POINTS):0]     sample_cnt;
`ifdef FFT_INPUT_FLUSH_EN
    logic                          flush;

    modport master (
        output in_valid, in_data, frame_ack, flush,
        input  in_ready, seg_hold, seg_D, frame_valid, sample_cnt
    );

    modport slave (
        input  in_valid, in_data, frame_ack, flush,
        output in_ready, seg_hold, seg_D, frame_valid, sample_cnt
    );
`else
    modport master (
        output in_valid, in_data, frame_ack,
        input  in_ready, seg_hold, seg_D, frame_valid, sample_cnt
    );

    modport slave (
        input  in_valid, in_data, frame_ack,
        output in_ready, seg_hold, seg_D, frame_valid, sample_cnt
    );
`endif

endinterface

// File: rtl/fft_sample_counter.sv
// Saturating 0..N_POINTS up-counter with synchronous clear and asynchronous reset.
module fft_sample_counter
    import fft_pkg::*;
#(
    parameter int N_POINTS = FFT_N_POINTS,
    localparam int CNT_W   = $clog2(N_POINTS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; the count never passes a full frame.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(N_POINTS))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fft_input_load_ctrl.sv
// Loads one frame into the FFT input shift chain and holds it until acknowledged.
// Optional zero-pad flush of a partial frame is built when FFT_INPUT_FLUSH_EN is defined.
module fft_input_load_ctrl
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_POINTS   = FFT_N_POINTS,
    localparam int CNT_W     = $clog2(N_POINTS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_input_load_ctrl_if.slave  bus
);

    load_state_e      state_q;
    load_state_e      state_d;
    logic             in_rdy_q;
    logic             frame_vld_q;
    logic             padding;
    logic [CNT_W-1:0] cnt;
    logic             last_slot;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_inc;

    assign last_slot = (cnt == CNT_W'(N_POINTS - 1));
    assign accept    = in_rdy_q & bus.in_valid & ~rst;
    assign cnt_clr   = frame_vld_q & bus.frame_ack;
    assign cnt_inc   = accept | padding;

    fft_sample_counter #(
        .N_POINTS (N_POINTS)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (cnt)
    );

    // A sample offered with flush is still accepted; completing the frame outranks flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (accept && last_slot) begin
                    state_d = FULL;
`ifdef FFT_INPUT_FLUSH_EN
                end else if (bus.flush && (cnt != '0)) begin
                    state_d = PAD;
`endif
                end
            end
`ifdef FFT_INPUT_FLUSH_EN
            PAD: begin
                if (last_slot) begin
                    state_d = FULL;
                end
            end
`endif
            FULL: begin
                if (bus.frame_ack) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Output flags are registered alongside the state so no input reaches them combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            in_rdy_q    <= 1'b1;
            frame_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_rdy_q    <= (state_d == FILL);
            frame_vld_q <= (state_d == FULL);
        end
    end

`ifdef FFT_INPUT_FLUSH_EN
    logic pad_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_q <= 1'b0;
        end else begin
            pad_q <= (state_d == PAD);
        end
    end

    assign padding = pad_q;
`else
    assign padding = 1'b0;
`endif

    // Hold is forced during reset so a partial frame is never disturbed by the abort.
    assign bus.in_ready    = in_rdy_q & ~rst;
    assign bus.seg_hold    = rst | (in_rdy_q ? ~bus.in_valid : ~padding);
    assign bus.seg_D       = padding ? {DATA_WIDTH{1'b0}} : bus.in_data;
    assign bus.frame_valid = frame_vld_q;
    assign bus.sample_cnt  = cnt;

endmodule

// File: tb/tb_fft_input_load_ctrl.sv
// Directed bench for fft_input_load_ctrl with a behavioural 64-deep input chain beside it.
module tb_fft_input_load_ctrl;

    localparam int DW = 32;
    localparam int N  = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_input_load_ctrl_if #(.DATA_WIDTH(DW), .N_POINTS(N)) bus();

    fft_input_load_ctrl #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // chain[0] is the head register fed by seg_D; chain[N-1] is the tail.
    logic [DW-1:0] chain [0:N-1];
    int shift_cnt = 0;

    always @(posedge clk) begin
        if (!bus.seg_hold) begin
            for (int i = N - 1; i > 0; i--) chain[i] <= chain[i-1];
            chain[0]  <= bus.seg_D;
            shift_cnt <= shift_cnt + 1;
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(base + k);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1 || bus.seg_hold !== 1'b0)
                $display("FAIL load_accept k=%0d in_ready=%b seg_hold=%b required 1 0", k, bus.in_ready, bus.seg_hold);
            else passes++;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic ack_frame();
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        #1;
        checks++;
        if (bus.sample_cnt !== 7'd0 || bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL ack_release cnt=%0d fv=%b rdy=%b required 0 0 1", bus.sample_cnt, bus.frame_valid, bus.in_ready);
        else passes++;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = '0;
        bus.frame_ack = 1'b0;
`ifdef FFT_INPUT_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        tick();
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.seg_hold !== 1'b1)
            $display("FAIL reset_outputs in_ready=%b seg_hold=%b required 0 1", bus.in_ready, bus.seg_hold);
        else passes++;
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.sample_cnt !== 7'd0)
            $display("FAIL reset_state fv=%b cnt=%0d required 0 0", bus.frame_valid, bus.sample_cnt);
        else passes++;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.seg_hold !== 1'b1)
            $display("FAIL reset_release in_ready=%b seg_hold=%b required 1 1", bus.in_ready, bus.seg_hold);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int s;
        s = shift_cnt;
        load(63, 1);
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.sample_cnt !== 7'd63)
            $display("FAIL b2b_before_last fv=%b cnt=%0d required 0 63", bus.frame_valid, bus.sample_cnt);
        else passes++;
        load(1, 64);
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.sample_cnt !== 7'd64 || bus.in_ready !== 1'b0 || bus.seg_hold !== 1'b1)
            $display("FAIL b2b_full fv=%b cnt=%0d rdy=%b hold=%b required 1 64 0 1",
                     bus.frame_valid, bus.sample_cnt, bus.in_ready, bus.seg_hold);
        else passes++;
        checks++;
        if (chain[0] !== 32'd64 || chain[N-1] !== 32'd1 || (shift_cnt - s) != 64)
            $display("FAIL b2b_chain head=%0d tail=%0d shifts=%0d required 64 1 64", chain[0], chain[N-1], shift_cnt - s);
        else passes++;
        ack_frame();
    endtask

    task automatic test_toggle();
        int acc;
        logic v;
        acc = 0;
        for (int c = 0; c < 128; c++) begin
            v = (c % 2 == 0);
            bus.in_valid = v;
            bus.in_data  = DW'(200 + acc);
            #1;
            checks++;
            if (bus.seg_hold !== ~v || bus.sample_cnt !== 7'(acc) || bus.frame_valid !== (acc == 64))
                $display("FAIL toggle c=%0d hold=%b cnt=%0d fv=%b required %b %0d %b",
                         c, bus.seg_hold, bus.sample_cnt, bus.frame_valid, ~v, acc, (acc == 64));
            else passes++;
            tick();
            if (v && acc < 64) acc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.frame_valid !== 1'b1 || chain[0] !== 32'd263 || chain[N-1] !== 32'd200)
            $display("FAIL toggle_frame fv=%b head=%0d tail=%0d required 1 263 200", bus.frame_valid, chain[0], chain[N-1]);
        else passes++;
    endtask

    task automatic test_full_backpressure();
        int s;
        s = shift_cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd499;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.seg_hold !== 1'b1 || bus.frame_valid !== 1'b1)
                $display("FAIL full_hold c=%0d rdy=%b hold=%b fv=%b required 0 1 1", c, bus.in_ready, bus.seg_hold, bus.frame_valid);
            else passes++;
            tick();
        end
        bus.in_data   = 32'd500;
        bus.frame_ack = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.seg_hold !== 1'b1)
            $display("FAIL ack_cycle rdy=%b hold=%b required 0 1", bus.in_ready, bus.seg_hold);
        else passes++;
        tick();
        bus.frame_ack = 1'b0;
        #1;
        checks++;
        if (bus.sample_cnt !== 7'd0 || bus.in_ready !== 1'b1 || bus.seg_hold !== 1'b0 || shift_cnt != s)
            $display("FAIL after_ack cnt=%0d rdy=%b hold=%b shifts=%0d required 0 1 0 0",
                     bus.sample_cnt, bus.in_ready, bus.seg_hold, shift_cnt - s);
        else passes++;
        tick();
        checks++;
        if (bus.sample_cnt !== 7'd1 || chain[0] !== 32'd500)
            $display("FAIL restart cnt=%0d head=%0d required 1 500", bus.sample_cnt, chain[0]);
        else passes++;
        load(63, 501);
        checks++;
        if (bus.frame_valid !== 1'b1 || chain[N-1] !== 32'd500)
            $display("FAIL restart_frame fv=%b tail=%0d required 1 500", bus.frame_valid, chain[N-1]);
        else passes++;
        ack_frame();
    endtask

    task automatic test_reset_mid();
        int s;
        load(37, 1000);
        checks++;
        if (bus.sample_cnt !== 7'd37)
            $display("FAIL mid_count cnt=%0d required 37", bus.sample_cnt);
        else passes++;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.seg_hold !== 1'b1 || bus.sample_cnt !== 7'd0)
            $display("FAIL mid_reset rdy=%b hold=%b cnt=%0d required 0 1 0", bus.in_ready, bus.seg_hold, bus.sample_cnt);
        else passes++;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.sample_cnt !== 7'd0 || bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL mid_release cnt=%0d fv=%b rdy=%b required 0 0 1", bus.sample_cnt, bus.frame_valid, bus.in_ready);
        else passes++;
        s = shift_cnt;
        load(64, 2000);
        checks++;
        if (bus.frame_valid !== 1'b1 || chain[0] !== 32'd2063 || chain[N-1] !== 32'd2000 || (shift_cnt - s) != 64)
            $display("FAIL mid_refill fv=%b head=%0d tail=%0d shifts=%0d required 1 2063 2000 64",
                     bus.frame_valid, chain[0], chain[N-1], shift_cnt - s);
        else passes++;
        ack_frame();
    endtask

    task automatic test_ack_in_fill();
        load(10, 3000);
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        checks++;
        if (bus.sample_cnt !== 7'd10 || bus.frame_valid !== 1'b0)
            $display("FAIL fill_ack cnt=%0d fv=%b required 10 0", bus.sample_cnt, bus.frame_valid);
        else passes++;
        load(53, 3010);
        checks++;
        if (bus.sample_cnt !== 7'd63 || bus.frame_valid !== 1'b0)
            $display("FAIL fill_ack_63 cnt=%0d fv=%b required 63 0", bus.sample_cnt, bus.frame_valid);
        else passes++;
        load(1, 3063);
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.sample_cnt !== 7'd64 || chain[0] !== 32'd3063 || chain[N-1] !== 32'd3000)
            $display("FAIL fill_ack_frame fv=%b cnt=%0d head=%0d tail=%0d required 1 64 3063 3000",
                     bus.frame_valid, bus.sample_cnt, chain[0], chain[N-1]);
        else passes++;
        ack_frame();
    endtask

`ifdef FFT_INPUT_FLUSH_EN
    task automatic test_flush();
        int bad;
        load(20, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int p = 0; p < 44; p++) begin
            #1;
            checks++;
            if (bus.seg_D !== '0 || bus.seg_hold !== 1'b0 || bus.in_ready !== 1'b0 || bus.frame_valid !== 1'b0)
                $display("FAIL pad p=%0d D=%0d hold=%b rdy=%b fv=%b required 0 0 0 0",
                         p, bus.seg_D, bus.seg_hold, bus.in_ready, bus.frame_valid);
            else passes++;
            tick();
        end
        bad = 0;
        for (int i = 0; i < 44; i++) if (chain[i] !== '0) bad++;
        for (int i = 44; i < N; i++) if (chain[i] !== DW'(64 - i)) bad++;
        checks++;
        if (bus.frame_valid !== 1'b1 || bad != 0)
            $display("FAIL flush_frame fv=%b bad_slots=%0d required 1 0", bus.frame_valid, bad);
        else passes++;
        ack_frame();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle();
        test_full_backpressure();
        test_reset_mid();
        test_ack_in_fill();
`ifdef FFT_INPUT_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
